// File: rtl/wormhole_output_allocator.sv
// Per-output wormhole allocator: round-robin arbitration, head-to-tail lock, credit flow control.
// Optional lock watchdog is enabled by defining ALLOC_TIMEOUT_EN.
module wormhole_output_allocator #(
  parameter int NUM_IN         = 5,
  parameter int MAX_CREDITS    = 4,
  parameter int CNT_W          = 3,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_IN-1:0] req,
  input  logic [NUM_IN-1:0] tail,
  input  logic              credit_in,
  output logic [NUM_IN-1:0] grant,
  output logic [NUM_IN-1:0] xbar_sel,
  output logic              valid_out,
  output logic [CNT_W-1:0]  credit_cnt,
  output logic              busy,
  output logic              credit_err,
  output logic              timeout
);

  localparam int IDX_W = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;

  if (TIMEOUT_CYCLES < 1 || (1 << CNT_W) <= MAX_CREDITS) begin : g_bad_cfg
    $error("wormhole_output_allocator: CNT_W cannot hold MAX_CREDITS or TIMEOUT_CYCLES < 1");
  end

  typedef enum logic {IDLE, LOCKED} state_e;

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  owner_q, owner_d;
  logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [NUM_IN-1:0] xbar_sel_q, xbar_sel_d;
  logic [CNT_W-1:0]  credit_cnt_q, credit_cnt_d;
  logic              credit_err_q, credit_err_d;

  logic              arb_found;
  logic [IDX_W-1:0]  arb_winner;
  logic [IDX_W-1:0]  cand;
  logic              owner_req;
  logic              tail_xfer;
  logic              wd_release;

  // Scan starts at rr_ptr and wraps, so the last owner gets lowest priority.
  // NOTE: every always_comb output gets a default first, so no path leaves a latch.
  always_comb begin
    arb_found  = 1'b0;
    arb_winner = rr_ptr_q;
    cand       = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      cand = IDX_W'((int'(rr_ptr_q) + k) % NUM_IN);
      if (!arb_found && req[cand]) begin
        arb_found  = 1'b1;
        arb_winner = cand;
      end
    end
  end

  assign owner_req = |(xbar_sel_q & req);
  assign grant     = (state_q == LOCKED && credit_cnt_q != '0) ? (xbar_sel_q & req) : '0;
  assign valid_out = |grant;
  assign tail_xfer = |(grant & tail);

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    rr_ptr_d   = rr_ptr_q;
    xbar_sel_d = xbar_sel_q;
    case (state_q)
      IDLE: begin
        if (arb_found) begin
          state_d    = LOCKED;
          owner_d    = arb_winner;
          xbar_sel_d = NUM_IN'(1) << arb_winner;
        end
      end
      LOCKED: begin
        if (tail_xfer) begin
          state_d    = IDLE;
          xbar_sel_d = '0;
          rr_ptr_d   = (owner_q == IDX_W'(NUM_IN - 1)) ? '0 : owner_q + IDX_W'(1);
        end else if (wd_release) begin
          state_d    = IDLE;
          xbar_sel_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A send and a returned credit in the same cycle cancel out.
  always_comb begin
    credit_cnt_d = credit_cnt_q;
    credit_err_d = credit_err_q;
    if (valid_out && !credit_in) begin
      credit_cnt_d = credit_cnt_q - CNT_W'(1);
    end else if (!valid_out && credit_in) begin
      if (credit_cnt_q == CNT_W'(MAX_CREDITS)) credit_err_d = 1'b1;
      else                                     credit_cnt_d = credit_cnt_q + CNT_W'(1);
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      owner_q      <= '0;
      rr_ptr_q     <= '0;
      xbar_sel_q   <= '0;
      credit_cnt_q <= CNT_W'(MAX_CREDITS);
      credit_err_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      rr_ptr_q     <= rr_ptr_d;
      xbar_sel_q   <= xbar_sel_d;
      credit_cnt_q <= credit_cnt_d;
      credit_err_q <= credit_err_d;
    end
  end

`ifdef ALLOC_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;
  logic            timeout_q;

  // Only idle-owner cycles count; a credit stall with req high restarts the count.
  always_comb begin
    wd_cnt_d   = '0;
    wd_release = 1'b0;
    if (state_q == LOCKED && !owner_req) begin
      if (wd_cnt_q == WD_W'(TIMEOUT_CYCLES - 1)) wd_release = 1'b1;
      else                                       wd_cnt_d   = wd_cnt_q + WD_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wd_cnt_q  <= '0;
      timeout_q <= 1'b0;
    end else begin
      wd_cnt_q  <= wd_cnt_d;
      timeout_q <= wd_release;
    end
  end

  assign timeout = timeout_q;
`else
  assign wd_release = 1'b0;
  assign timeout    = 1'b0;
`endif

  assign xbar_sel   = xbar_sel_q;
  assign busy       = (state_q == LOCKED);
  assign credit_cnt = credit_cnt_q;
  assign credit_err = credit_err_q;

endmodule

// File: tb/tb_wormhole_output_allocator.sv
// Bench for wormhole_output_allocator: directed scenarios plus a random run against a packet-level model.
module tb_wormhole_output_allocator;
  localparam int N    = 5;
  localparam int MAXC = 4;
  localparam int CW   = 3;
  localparam int TO   = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  req, tail;
  logic          credit_in;
  logic [N-1:0]  grant, xbar_sel;
  logic          valid_out;
  logic [CW-1:0] credit_cnt;
  logic          busy, credit_err, timeout;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  wormhole_output_allocator #(
    .NUM_IN(N), .MAX_CREDITS(MAXC), .CNT_W(CW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .tail(tail), .credit_in(credit_in),
    .grant(grant), .xbar_sel(xbar_sel), .valid_out(valid_out),
    .credit_cnt(credit_cnt), .busy(busy), .credit_err(credit_err), .timeout(timeout)
  );

  // Packet-level reference: lock owner, round-robin start point, credit pool, sticky error.
  bit m_locked;
  int m_owner, m_rr, m_cred, m_wd;
  bit m_err, m_to;

  function automatic logic [N-1:0] onehot(input int idx);
    logic [N-1:0] one;
    one = 1;
    return one << idx;
  endfunction

  function automatic logic [N-1:0] exp_grant();
    if (m_locked && req[m_owner] && m_cred > 0) return onehot(m_owner);
    return '0;
  endfunction

  function automatic logic [N-1:0] exp_sel();
    return m_locked ? onehot(m_owner) : '0;
  endfunction

  task automatic model_reset();
    m_locked = 0; m_owner = 0; m_rr = 0; m_cred = MAXC; m_wd = 0; m_err = 0; m_to = 0;
  endtask

  task automatic set_in(input logic [N-1:0] r, input logic [N-1:0] t, input logic c);
    req = r; tail = t; credit_in = c;
    #1;
  endtask

  // Advance the model by the current inputs, then move to the next sampling point.
  task automatic tick();
    bit sent;
    sent = (exp_grant() != 0);
    if (rst) begin
      model_reset();
    end else begin
      m_to = 0;
      if (sent) m_cred = m_cred - 1 + int'(credit_in);
      else if (credit_in) begin
        if (m_cred == MAXC) m_err = 1;
        else m_cred++;
      end
      if (!m_locked) begin
        m_wd = 0;
        for (int k = 0; k < N; k++) begin
          if (!m_locked && req[(m_rr + k) % N]) begin
            m_locked = 1; m_owner = (m_rr + k) % N;
          end
        end
      end else if (sent && tail[m_owner]) begin
        m_locked = 0; m_rr = (m_owner + 1) % N;
      end
`ifdef ALLOC_TIMEOUT_EN
      else if (!req[m_owner]) begin
        m_wd++;
        if (m_wd == TO) begin m_locked = 0; m_to = 1; m_wd = 0; end
      end else m_wd = 0;
`endif
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1; set_in('0, '0, 0); tick(); rst = 0;
  endtask

  task automatic test_reset();
    rst = 1; set_in(5'b11111, '0, 1); tick(); rst = 0;
    set_in('0, '0, 0);
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_cmp++; if (xbar_sel !== '0) begin n_bad++; $display("FAIL reset_xbar_sel: got %b expected 00000", xbar_sel); end
    n_cmp++; if (credit_cnt !== CW'(MAXC)) begin n_bad++; $display("FAIL reset_credit_cnt: got %0d expected %0d", credit_cnt, MAXC); end
    n_cmp++; if (credit_err !== 1'b0 || timeout !== 1'b0) begin n_bad++; $display("FAIL reset_err_timeout: got %b%b expected 00", credit_err, timeout); end
    n_cmp++; if (grant !== '0 || valid_out !== 1'b0) begin n_bad++; $display("FAIL reset_grant: got %b/%b expected 00000/0", grant, valid_out); end
  endtask

  task automatic test_two_flit_packet();
    set_in(5'b00001, '0, 0);
    n_cmp++; if (grant !== '0) begin n_bad++; $display("FAIL basic_arb_no_grant: got %b expected 00000", grant); end
    tick();
    set_in(5'b00001, '0, 0);
    n_cmp++; if (xbar_sel !== 5'b00001) begin n_bad++; $display("FAIL basic_xbar_sel: got %b expected 00001", xbar_sel); end
    n_cmp++; if (grant !== 5'b00001) begin n_bad++; $display("FAIL basic_grant_c1: got %b expected 00001", grant); end
    tick();
    set_in(5'b00001, 5'b00001, 0);
    n_cmp++; if (grant !== 5'b00001) begin n_bad++; $display("FAIL basic_grant_c2: got %b expected 00001", grant); end
    tick();
    set_in('0, '0, 0);
    n_cmp++; if (busy !== 1'b0 || xbar_sel !== '0) begin n_bad++; $display("FAIL basic_unlock: got busy=%b sel=%b expected 0/00000", busy, xbar_sel); end
    n_cmp++; if (credit_cnt !== 3'd2) begin n_bad++; $display("FAIL basic_credits: got %0d expected 2", credit_cnt); end
    tick(); set_in('0, '0, 1); tick(); set_in('0, '0, 1); tick();
  endtask

  task automatic test_round_robin();
    logic [N-1:0] seq [4];
    seq[0] = 5'b00001; seq[1] = 5'b10000; seq[2] = 5'b00001; seq[3] = 5'b10000;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      set_in(5'b10001, 5'b11111, 0);
      n_cmp++; if (grant !== '0) begin n_bad++; $display("FAIL rr_arb_gap[%0d]: got %b expected 00000", i, grant); end
      tick();
      set_in(5'b10001, 5'b11111, 1);
      n_cmp++; if (grant !== seq[i]) begin n_bad++; $display("FAIL rr_grant[%0d]: got %b expected %b", i, grant, seq[i]); end
      tick();
    end
    set_in('0, '0, 0);
    n_cmp++; if (credit_cnt !== CW'(MAXC) || credit_err !== 1'b0) begin n_bad++; $display("FAIL rr_credits: got %0d err=%b expected 4 err=0", credit_cnt, credit_err); end
    tick();
  endtask

  task automatic test_credit_stall();
    do_reset();
    set_in(5'b00100, '0, 0); tick();
    for (int i = 0; i < 4; i++) begin
      set_in(5'b00100, '0, 0);
      n_cmp++; if (grant !== 5'b00100) begin n_bad++; $display("FAIL stall_flit[%0d]: got %b expected 00100", i, grant); end
      tick();
    end
    set_in(5'b00100, 5'b00100, 0);
    n_cmp++; if (credit_cnt !== 3'd0) begin n_bad++; $display("FAIL stall_cnt_zero: got %0d expected 0", credit_cnt); end
    n_cmp++; if (grant !== '0 || busy !== 1'b1) begin n_bad++; $display("FAIL stall_blocked: got grant=%b busy=%b expected 00000/1", grant, busy); end
    tick();
    set_in(5'b00100, 5'b00100, 1);
    n_cmp++; if (valid_out !== 1'b0) begin n_bad++; $display("FAIL stall_still_blocked: got %b expected 0", valid_out); end
    tick();
    set_in(5'b00100, 5'b00100, 0);
    n_cmp++; if (credit_cnt !== 3'd1 || grant !== 5'b00100) begin n_bad++; $display("FAIL stall_resume: got cnt=%0d grant=%b expected 1/00100", credit_cnt, grant); end
    tick();
    set_in('0, '0, 0);
    n_cmp++; if (busy !== 1'b0 || credit_cnt !== 3'd0) begin n_bad++; $display("FAIL stall_done: got busy=%b cnt=%0d expected 0/0", busy, credit_cnt); end
    for (int i = 0; i < 4; i++) begin set_in('0, '0, 1); tick(); end
  endtask

  task automatic test_same_cycle_credit();
    do_reset();
    set_in(5'b00010, '0, 0); tick();
    set_in(5'b00010, '0, 0); tick();
    set_in(5'b00010, '0, 0); tick();
    set_in(5'b00010, '0, 1);
    n_cmp++; if (credit_cnt !== 3'd2 || valid_out !== 1'b1) begin n_bad++; $display("FAIL same_pre: got cnt=%0d valid=%b expected 2/1", credit_cnt, valid_out); end
    tick();
    set_in(5'b00010, 5'b00010, 1);
    n_cmp++; if (credit_cnt !== 3'd2) begin n_bad++; $display("FAIL same_hold: got %0d expected 2", credit_cnt); end
    tick();
    set_in('0, '0, 1);
    n_cmp++; if (credit_cnt !== 3'd2 || busy !== 1'b0) begin n_bad++; $display("FAIL same_tail: got cnt=%0d busy=%b expected 2/0", credit_cnt, busy); end
    tick(); set_in('0, '0, 1); tick();
    set_in('0, '0, 1);
    n_cmp++; if (credit_cnt !== 3'd4 || credit_err !== 1'b0) begin n_bad++; $display("FAIL same_full: got cnt=%0d err=%b expected 4/0", credit_cnt, credit_err); end
    tick();
    set_in('0, '0, 0);
    n_cmp++; if (credit_err !== 1'b1 || credit_cnt !== 3'd4) begin n_bad++; $display("FAIL overflow_err: got err=%b cnt=%0d expected 1/4", credit_err, credit_cnt); end
    tick();
  endtask

  task automatic test_mid_packet_reset();
    do_reset();
    set_in(5'b01000, 5'b01000, 0); tick();
    set_in(5'b01000, 5'b01000, 0); tick();
    set_in(5'b01000, '0, 0); tick();
    set_in(5'b01000, '0, 0); tick();
    rst = 1; set_in(5'b01000, '0, 0); tick(); rst = 0;
    set_in(5'b11111, 5'b11111, 0);
    n_cmp++; if (busy !== 1'b0 || xbar_sel !== '0) begin n_bad++; $display("FAIL midrst_unlock: got busy=%b sel=%b expected 0/00000", busy, xbar_sel); end
    n_cmp++; if (credit_cnt !== CW'(MAXC)) begin n_bad++; $display("FAIL midrst_credits: got %0d expected 4", credit_cnt); end
    tick();
    set_in(5'b11111, 5'b11111, 0);
    n_cmp++; if (xbar_sel !== 5'b00001) begin n_bad++; $display("FAIL midrst_rr_ptr: got %b expected 00001", xbar_sel); end
    tick();
  endtask

  task automatic test_watchdog();
    do_reset();
    set_in(5'b00001, 5'b00001, 0); tick();
    set_in(5'b00001, 5'b00001, 0); tick();
    set_in(5'b00100, '0, 0); tick();
    set_in(5'b00100, '0, 0); tick();
`ifdef ALLOC_TIMEOUT_EN
    for (int i = 0; i < TO; i++) begin
      set_in('0, '0, 0);
      n_cmp++; if (busy !== 1'b1 || timeout !== 1'b0) begin n_bad++; $display("FAIL wd_holding[%0d]: got busy=%b to=%b expected 1/0", i, busy, timeout); end
      tick();
    end
    set_in(5'b11111, 5'b11111, 0);
    n_cmp++; if (busy !== 1'b0 || timeout !== 1'b1 || xbar_sel !== '0) begin n_bad++; $display("FAIL wd_release: got busy=%b to=%b sel=%b expected 0/1/00000", busy, timeout, xbar_sel); end
    tick();
    set_in(5'b11111, 5'b11111, 0);
    n_cmp++; if (timeout !== 1'b0) begin n_bad++; $display("FAIL wd_pulse_width: got %b expected 0", timeout); end
    n_cmp++; if (xbar_sel !== 5'b00010) begin n_bad++; $display("FAIL wd_rr_kept: got %b expected 00010", xbar_sel); end
    tick();
`else
    for (int i = 0; i < 100; i++) begin set_in('0, '0, 0); tick(); end
    set_in(5'b00100, 5'b00100, 0);
    n_cmp++; if (busy !== 1'b1 || xbar_sel !== 5'b00100 || timeout !== 1'b0) begin n_bad++; $display("FAIL nowd_locked: got busy=%b sel=%b to=%b expected 1/00100/0", busy, xbar_sel, timeout); end
    n_cmp++; if (grant !== 5'b00100) begin n_bad++; $display("FAIL nowd_resume: got %b expected 00100", grant); end
    tick();
`endif
    set_in('0, '0, 0);
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL wd_end_idle: got %b expected 0", busy); end
    tick();
  endtask

  task automatic test_random();
    logic [N-1:0] eg;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 599) == 0);
      if ((i / 40) % 9 == 4) set_in('0, N'($urandom & $urandom & $urandom), 1'($urandom_range(0, 3) == 0));
      else set_in(N'($urandom | $urandom), N'($urandom & $urandom & $urandom), 1'($urandom_range(0, 2) == 0));
      eg = exp_grant();
      n_cmp++; if (grant !== eg || valid_out !== (eg != 0)) begin n_bad++; $display("FAIL rand_grant@%0d: got %b/%b expected %b/%b", i, grant, valid_out, eg, (eg != 0)); end
      n_cmp++; if (xbar_sel !== exp_sel() || busy !== m_locked) begin n_bad++; $display("FAIL rand_lock@%0d: got sel=%b busy=%b expected %b/%b", i, xbar_sel, busy, exp_sel(), m_locked); end
      n_cmp++; if (credit_cnt !== CW'(m_cred) || credit_err !== m_err) begin n_bad++; $display("FAIL rand_credit@%0d: got %0d err=%b expected %0d err=%b", i, credit_cnt, credit_err, m_cred, m_err); end
      n_cmp++; if (timeout !== m_to) begin n_bad++; $display("FAIL rand_timeout@%0d: got %b expected %b", i, timeout, m_to); end
      tick();
    end
    rst = 0;
  endtask

  initial begin
    rst = 1; req = '0; tail = '0; credit_in = 0;
    model_reset();
    @(negedge clk);
    test_reset();
    test_two_flit_packet();
    test_round_robin();
    test_credit_stall();
    test_same_cycle_credit();
    test_mid_packet_reset();
    test_watchdog();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
